// File: rtl/alu_pipe.sv
// Handshaked EX-stage ALU: 1-cycle ops into a registered output, optional iterative
// shift-add multiplier built only when ALU_MUL_EN is defined (opcode E is illegal otherwise).
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  logic             accept;
  logic             is_mul, mul_done, idle, mul_ovf;
  logic [WIDTH-1:0] mul_res;
  logic [TAG_W-1:0] mul_tag;

  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_ill;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  assign in_ready = idle & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  assign sum  = in_a + in_b;
  assign diff = in_b - in_a;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    unique case (in_op)
      4'h0: alu_res = sum;
      4'h1: alu_res = in_b << (WIDTH / 2);
      4'h2: alu_res = in_a | in_b;
      4'h3: begin
        alu_res = sum;
        alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'h4: alu_res = in_a & in_b;
      4'h5: alu_res = diff;
      4'h6: begin
        alu_res = diff;
        alu_ovf = (in_b[WIDTH-1] != in_a[WIDTH-1]) & (diff[WIDTH-1] != in_b[WIDTH-1]);
      end
      4'h7: alu_res = in_b << in_shamt;
      4'h8: alu_res = in_b >> in_shamt;
      4'h9: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      4'hA: alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      4'hB: alu_res = ~(in_a | in_b);
      4'hC: alu_res = in_b;
      4'hD: alu_res = $signed(in_b) >>> in_shamt;
      // E (only reaches here without the multiplier) and F
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  typedef enum logic [0:0] {StIdle, StRun} state_e;
  state_e state_q, state_d;

  logic [2*WIDTH-1:0] mcand_q, acc_q, acc_sum;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW-1:0]     cnt_q;
  logic [TAG_W-1:0]   mtag_q;

  assign is_mul   = (in_op == 4'hE);
  assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_done = (state_q == StRun) && (cnt_q == SHW'(WIDTH - 1));
  assign mul_res  = acc_sum[WIDTH-1:0];
  assign mul_ovf  = |acc_sum[2*WIDTH-1:WIDTH];
  assign mul_tag  = mtag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && is_mul) state_d = StRun;
      StRun:   if (mul_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    idle = (state_q == StIdle);
    busy = (state_q == StRun);
  end

  // Multiplicand shifts left while the multiplier shifts right, LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mtag_q   <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, in_a};
      mplier_q <= in_b;
      acc_q    <= '0;
      cnt_q    <= '0;
      mtag_q   <= in_tag;
    end else if (state_q == StRun) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_sum;
      cnt_q    <= cnt_q + 1'b1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
  assign mul_ovf  = 1'b0;
  assign mul_tag  = '0;
  assign idle     = 1'b1;
  assign busy     = 1'b0;
`endif

  // An accept needs a free output register, so the multiplier load never collides.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    tag_d       = tag_q;
    if (accept && !is_mul) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      ovf_d       = alu_ovf;
      ill_d       = alu_ill;
      tag_d       = in_tag;
    end else if (mul_done) begin
      out_valid_d = 1'b1;
      result_d    = mul_res;
      zero_d      = (mul_res == '0);
      ovf_d       = mul_ovf;
      ill_d       = 1'b0;
      tag_d       = mul_tag;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
      tag_q       <= tag_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = result_q;
  assign out_zero     = zero_q;
  assign out_overflow = ovf_q;
  assign out_illegal  = ill_q;
  assign out_tag      = tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32): vector table for single-cycle ops plus
// hand sequences for back-pressure, reset and the multiplier when ALU_MUL_EN is defined.
module tb_alu_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_shamt;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_overflow, out_illegal;
  logic [3:0]  out_tag;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_shamt     (in_shamt),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_illegal  (out_illegal),
    .out_tag      (out_tag),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        il;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input string name);
    in_op     = v.op;
    in_a      = v.a;
    in_b      = v.b;
    in_shamt  = v.sh;
    in_tag    = v.tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({name, "_valid"}, out_valid, 1);
    check({name, "_res"}, out_result, v.res);
    check({name, "_zero"}, out_zero, v.z);
    check({name, "_ovf"}, out_overflow, v.o);
    check({name, "_ill"}, out_illegal, v.il);
    check({name, "_tag"}, out_tag, v.tag);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic mul_run(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] res, input logic z, input logic o);
    in_op = 4'hE; in_a = a; in_b = b; in_shamt = '0; in_tag = tag;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      check("mul_run_busy_ready_valid", {busy, in_ready, out_valid}, 3'b100);
      tick();
    end
    check("mul_valid", out_valid, 1);
    check("mul_res", out_result, res);
    check("mul_zero", out_zero, z);
    check("mul_ovf", out_overflow, o);
    check("mul_tag", out_tag, tag);
    check("mul_busy_done", busy, 0);
  endtask

  initial begin
    vec_t v;
    int stray;
    vecs[0]  = '{4'h3, 32'h7FFFFFFF, 32'h00000001, 5'd0,  4'd3,  32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{4'h6, 32'h00000005, 32'h00000005, 5'd0,  4'd1,  32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{4'h6, 32'h00000001, 32'h80000000, 5'd0,  4'd2,  32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{4'h0, 32'hFFFFFFFF, 32'h00000001, 5'd0,  4'd4,  32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'h1, 32'h00000000, 32'h00001234, 5'd0,  4'd5,  32'h12340000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'h2, 32'h000000F0, 32'h0000000F, 5'd0,  4'd6,  32'h000000FF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'h4, 32'h0000F0F0, 32'h0000FF00, 5'd0,  4'd7,  32'h0000F000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'h5, 32'h00000001, 32'h00000000, 5'd0,  4'd8,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'h7, 32'h00000000, 32'h00000001, 5'd31, 4'd9,  32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'h8, 32'h00000000, 32'h80000000, 5'd4,  4'd10, 32'h08000000, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'hD, 32'h00000000, 32'h80000000, 5'd4,  4'd11, 32'hF8000000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'hD, 32'h00000000, 32'h00001234, 5'd0,  4'd12, 32'h00001234, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'h9, 32'hFFFFFFFF, 32'h00000001, 5'd0,  4'd13, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'hA, 32'hFFFFFFFF, 32'h00000001, 5'd0,  4'd14, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'hB, 32'h00000000, 32'h00000000, 5'd0,  4'd15, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'hC, 32'h12345678, 32'hDEADBEEF, 5'd0,  4'd0,  32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{4'hF, 32'h12345678, 32'h9ABCDEF0, 5'd3,  4'd6,  32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{4'h3, 32'h80000000, 32'h80000000, 5'd0,  4'd7,  32'h00000000, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_shamt = '0; in_tag = '0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_res", out_result, 0);
    check("rst_flags", {out_zero, out_overflow, out_illegal}, 3'b000);
    check("rst_tag", out_tag, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: SLL held for three cycles while an OR waits, then taken with no bubble.
    drain();
    check("drain_valid", out_valid, 0);
    in_op = 4'h7; in_a = '0; in_b = 32'h1; in_shamt = 5'd31; in_tag = 4'd9;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_op = 4'h2; in_a = 32'h3; in_b = 32'h4; in_shamt = '0; in_tag = 4'd10;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_res", out_result, 32'h80000000);
      check("bp_hold_tag", out_tag, 9);
      check("bp_in_ready_low", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_res", out_result, 32'h7);
    check("bp_next_tag", out_tag, 10);
    tick();
    check("bp_drained", out_valid, 0);

`ifdef ALU_MUL_EN
    mul_run(32'h00010000, 32'h00010000, 4'd5, 32'h0, 1'b1, 1'b1);
    mul_run(32'h7, 32'h6, 4'd6, 32'd42, 1'b0, 1'b0);
    drain();
    // Reset at RUN cycle 10 must discard the multiply.
    in_op = 4'hE; in_a = 32'd3; in_b = 32'd3; in_tag = 4'd2;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("midmul_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midmul_rst_valid", out_valid, 0);
    check("midmul_rst_busy", busy, 0);
`else
    v = '{4'hE, 32'h7, 32'h6, 5'd0, 4'd11, 32'h0, 1'b1, 1'b0, 1'b1};
    apply(v, "op_e_illegal");
    check("op_e_busy", busy, 0);
    // Reset while a result is being held must clear it.
    in_op = 4'h0; in_a = 32'd1; in_b = 32'd1; in_tag = 4'd4;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("held_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("held_rst_valid", out_valid, 0);
    check("held_rst_res", out_result, 0);
    check("held_rst_tag", out_tag, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    v = '{4'h0, 32'd2, 32'd3, 5'd0, 4'd1, 32'd5, 1'b0, 1'b0, 1'b0};
    apply(v, "post_rst_addu");
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) stray++;
    end
    check("no_stale_result", stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU, for the EX stage.
- Operands arrive with a valid/ready handshake and an opaque tag. Results leave through a registered output with their own handshake.
- Single-cycle ops have 1-cycle latency. An iterative shift-add multiplier (optional) is sequenced by an internal FSM.
- Flags are computed from the result of the same operation, never from a previous result.

Parameters:
- WIDTH, 32, operand/result width (even, >=8); localparam SHW = $clog2(WIDTH).
- TAG_W, 4, width of the pass-through tag (destination reg id / ROB slot).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- in_op  in  4  opcode (see Behaviour).
- in_a  in  WIDTH  operand A (rs).
- in_b  in  WIDTH  operand B (rt/imm).
- in_shamt  in  SHW  shift amount.
- in_tag  in  TAG_W  tag, returned unchanged with the result.
- out_valid  out  1  result held on outputs.
- out_ready  in  1  consumer takes result this cycle.
- out_result  out  WIDTH  result.
- out_zero  out  1  out_result == 0.
- out_overflow  out  1  signed overflow (ADD/SUB), product truncation (MUL).
- out_illegal  out  1  opcode reserved or not compiled in.
- out_tag  out  TAG_W  tag of this result.
- busy  out  1  multiplier FSM not IDLE.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_result=0, all flags 0, out_tag=0, FSM=IDLE, busy=0. A multiply in flight is discarded and never emitted.
- Handshake:
  - Accept when in_valid & in_ready.
  - in_ready = (state==IDLE) & (~out_valid | out_ready), combinational.
  - Output register is held stable while out_valid & ~out_ready.
  - out_valid drops after the out_ready cycle unless a new result loads the same edge. Back-to-back throughput is 1/cycle with no bubble.
- Opcodes (A=in_a, B=in_b):
  - 0 ADDU: A+B.
  - 1 LUI: B<<(WIDTH/2).
  - 2 OR.
  - 3 ADD: A+B, signed.
  - 4 AND.
  - 5 SUBU: B-A.
  - 6 SUB: B-A, signed.
  - 7 SLL: B<<shamt.
  - 8 SRL: B>>shamt, logical.
  - 9 SLT: signed A<B -> 1 else 0.
  - A SLTU: unsigned A<B.
  - B NOR.
  - C PASSB: B (JR).
  - D SRA: B>>>shamt, arithmetic.
  - E MUL: low WIDTH bits of unsigned A*B.
  - F: reserved.
- Arithmetic is modulo 2^WIDTH.
- ADD overflow = (A[msb]==B[msb]) & (R[msb]!=A[msb]).
- SUB overflow = (B[msb]!=A[msb]) & (R[msb]!=B[msb]).
- Overflow is 0 for all other single-cycle ops. out_zero is set on any op whose result is 0, including when overflow is set.
- Illegal opcode: accepted normally; 1-cycle latency; result 0, out_zero=1, out_illegal=1, out_overflow=0.
- Single-cycle ops: result/flags/tag registered at the accept edge; out_valid=1 next cycle (latency 1).
- MUL FSM, states IDLE -> RUN -> IDLE:
  - Accepting MUL captures A, B, tag; clears a 2*WIDTH accumulator; counter=0; state RUN; busy=1.
  - RUN: one multiplier bit per cycle (LSB first) for WIDTH cycles.
  - On the cycle with counter==WIDTH-1, the output register loads and the state returns to IDLE.
  - Total latency WIDTH+1 cycles from accept to out_valid.
  - out_overflow = |product[2W-1:W]; out_zero from low half.
  - in_ready=0 throughout RUN.
  - RUN never starts while a previous result is unconsumed, because accept requires the output register to be free. The final load therefore never collides.
- Shift amounts span 0..WIDTH-1; shamt=0 passes B unchanged.

Optional Feature:
- ALU_MUL_EN defined: MUL (opcode E) and the FSM/accumulator are built as above.
- Undefined: no multiplier logic; opcode E is treated as illegal (1-cycle, out_illegal=1); busy tied 0; FSM stays IDLE.

Test Plan:
- ADD, WIDTH=32: A=0x7FFFFFFF, B=1, tag=3 -> next cycle out_valid=1, result 0x80000000, overflow=1, zero=0, tag=3.
- SUB: A=5, B=5 -> result 0, zero=1, overflow=0. Then SUB A=1, B=0x80000000 -> result 0x7FFFFFFF, overflow=1.
- Back-pressure: issue SLL B=1 shamt=31, hold out_ready=0 for 3 cycles -> result 0x80000000 held stable, in_ready=0. Raise out_ready with a new OR offered -> accepted the same cycle, next result follows with no bubble.
- MUL (ALU_MUL_EN): A=0x10000, B=0x10000 -> busy/in_ready=0 for 32 cycles, out_valid at cycle 33, result 0, zero=1, overflow=1. A=7, B=6 -> result 42.
- Reset mid-MUL: deassert rst_n at RUN cycle 10 -> out_valid=0, busy=0 immediately. After release, ADDU 2+3 -> result 5, no stale MUL result ever emitted.
- Opcode F (and E without ALU_MUL_EN) -> 1-cycle, result 0, out_illegal=1, zero=1.
